// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS32 control FSM: fetch/decode/execute/memory/write-back sequencing with memory
// handshake timeout, sticky HALT on bad opcode or timeout, and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned ENABLE_IMM  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opc,
  input  logic [5:0]           func,
  input  logic                 memReady,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic                 iorD,
  output logic                 isJmp,
  output logic                 isBeq,
  output logic                 isBne,
  output logic [1:0]           rfWriteDataSel,
  output logic                 rfWriteAddrSel,
  output logic                 rfWriteEnable,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 aluSrc,
  output logic                 bitXtend,
  output logic [2:0]           aluFunc,
  output logic                 invOpcode,
  output logic                 memErr,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned CmpW  = WaitW + 1;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExec   = 4'd3,
    StMemRd  = 4'd4,
    StMemWr  = 4'd5,
    StWb     = 4'd6,
    StBranch = 4'd7,
    StJump   = 4'd8,
    StHalt   = 4'd9
  } state_e;

  typedef enum logic [2:0] {ClsR, ClsImm, ClsLw, ClsSw, ClsBeq, ClsBne, ClsJmp} cls_e;

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d, dec_cls;
  logic [2:0]           alu_q, alu_d, dec_alu;
  logic                 zext_q, zext_d, dec_zext, dec_valid;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 inv_q, inv_d, err_q, err_d;
  logic                 timeout_hit;

  logic                 iord_q, iord_d, is_jmp_q, is_jmp_d, is_beq_q, is_beq_d;
  logic                 is_bne_q, is_bne_d, rf_waddr_sel_q, rf_waddr_sel_d, rf_we_q, rf_we_d;
  logic                 mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic                 alu_src_q, alu_src_d, bit_xtend_q, bit_xtend_d;
  logic [1:0]           rf_wdata_sel_q, rf_wdata_sel_d;
  logic [2:0]           alu_func_q, alu_func_d;

  // Instruction classification, only consumed while in DECODE.
  always_comb begin
    dec_valid = 1'b1;
    dec_cls   = ClsR;
    dec_alu   = AluAdd;
    dec_zext  = 1'b0;
    case (opc)
      6'h00: begin
        case (func)
          6'h20:   dec_alu = AluAdd;
          6'h22:   dec_alu = AluSub;
          6'h24:   dec_alu = AluAnd;
          6'h25:   dec_alu = AluOr;
          6'h2A:   dec_alu = AluSlt;
          default: dec_valid = 1'b0;
        endcase
      end
      6'h08: begin dec_cls = ClsImm; dec_alu = AluAdd; dec_valid = (ENABLE_IMM != 0); end
      6'h0A: begin dec_cls = ClsImm; dec_alu = AluSlt; dec_valid = (ENABLE_IMM != 0); end
      6'h0C: begin
        dec_cls = ClsImm; dec_alu = AluAnd; dec_zext = 1'b1; dec_valid = (ENABLE_IMM != 0);
      end
      6'h0D: begin
        dec_cls = ClsImm; dec_alu = AluOr; dec_zext = 1'b1; dec_valid = (ENABLE_IMM != 0);
      end
      6'h23:   dec_cls = ClsLw;
      6'h2B:   dec_cls = ClsSw;
      6'h04:   dec_cls = ClsBeq;
      6'h05:   dec_cls = ClsBne;
      6'h02:   dec_cls = ClsJmp;
      default: dec_valid = 1'b0;
    endcase
  end

  // The ready-on-the-limit cycle wins because timeout_hit requires memReady low.
  assign timeout_hit = (MEM_TIMEOUT != 0) && !memReady &&
                       (({1'b0, wait_q} + CmpW'(1)) == CmpW'(MEM_TIMEOUT));

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_d     = alu_q;
    zext_d    = zext_q;
    wait_d    = '0;
    retired_d = retired_q;
    inv_d     = inv_q;
    err_d     = err_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch, StMemRd, StMemWr: begin
        if (memReady) begin
          case (state_q)
            StFetch: state_d = StDecode;
            StMemRd: state_d = StWb;
            default: begin
              state_d   = StFetch;
              retired_d = retired_q + CNT_WIDTH'(1);
            end
          endcase
        end else if (timeout_hit) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StDecode: begin
        if (dec_valid) begin
          cls_d  = dec_cls;
          alu_d  = dec_alu;
          zext_d = dec_zext;
          case (dec_cls)
            ClsBeq, ClsBne: state_d = StBranch;
            ClsJmp:         state_d = StJump;
            default:        state_d = StExec;
          endcase
        end else begin
          inv_d   = 1'b1;
          state_d = StHalt;
        end
      end
      StExec: begin
        case (cls_q)
          ClsLw:   state_d = StMemRd;
          ClsSw:   state_d = StMemWr;
          default: state_d = StWb;
        endcase
      end
      StWb, StBranch, StJump: begin
        state_d   = StFetch;
        retired_d = retired_q + CNT_WIDTH'(1);
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Control outputs are registered from the state being entered.
  always_comb begin
    iord_d         = 1'b0;
    is_jmp_d       = 1'b0;
    is_beq_d       = 1'b0;
    is_bne_d       = 1'b0;
    rf_wdata_sel_d = 2'b00;
    rf_waddr_sel_d = 1'b0;
    rf_we_d        = 1'b0;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    alu_src_d      = 1'b0;
    bit_xtend_d    = 1'b0;
    alu_func_d     = 3'b000;
    case (state_d)
      StFetch: mem_read_d = 1'b1;
      StExec: begin
        alu_src_d   = (cls_d != ClsR);
        alu_func_d  = alu_d;
        bit_xtend_d = zext_d;
      end
      StMemRd: begin mem_read_d = 1'b1; iord_d = 1'b1; end
      StMemWr: begin mem_write_d = 1'b1; iord_d = 1'b1; end
      StWb: begin
        rf_we_d        = 1'b1;
        rf_waddr_sel_d = (cls_d == ClsR);
        rf_wdata_sel_d = (cls_d == ClsLw) ? 2'b01 : 2'b00;
      end
      StBranch: begin
        alu_func_d = AluSub;
        is_beq_d   = (cls_d == ClsBeq);
        is_bne_d   = (cls_d == ClsBne);
      end
      StJump:  is_jmp_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cls_q          <= ClsR;
      alu_q          <= 3'b000;
      zext_q         <= 1'b0;
      wait_q         <= '0;
      retired_q      <= '0;
      inv_q          <= 1'b0;
      err_q          <= 1'b0;
      iord_q         <= 1'b0;
      is_jmp_q       <= 1'b0;
      is_beq_q       <= 1'b0;
      is_bne_q       <= 1'b0;
      rf_wdata_sel_q <= 2'b00;
      rf_waddr_sel_q <= 1'b0;
      rf_we_q        <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      alu_src_q      <= 1'b0;
      bit_xtend_q    <= 1'b0;
      alu_func_q     <= 3'b000;
    end else begin
      state_q        <= state_d;
      cls_q          <= cls_d;
      alu_q          <= alu_d;
      zext_q         <= zext_d;
      wait_q         <= wait_d;
      retired_q      <= retired_d;
      inv_q          <= inv_d;
      err_q          <= err_d;
      iord_q         <= iord_d;
      is_jmp_q       <= is_jmp_d;
      is_beq_q       <= is_beq_d;
      is_bne_q       <= is_bne_d;
      rf_wdata_sel_q <= rf_wdata_sel_d;
      rf_waddr_sel_q <= rf_waddr_sel_d;
      rf_we_q        <= rf_we_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      alu_src_q      <= alu_src_d;
      bit_xtend_q    <= bit_xtend_d;
      alu_func_q     <= alu_func_d;
    end
  end

  // IR and PC load in the very cycle the fetch completes.
  assign irWrite        = (state_q == StFetch) && memReady;
  assign pcWrite        = (state_q == StFetch) && memReady;
  assign iorD           = iord_q;
  assign isJmp          = is_jmp_q;
  assign isBeq          = is_beq_q;
  assign isBne          = is_bne_q;
  assign rfWriteDataSel = rf_wdata_sel_q;
  assign rfWriteAddrSel = rf_waddr_sel_q;
  assign rfWriteEnable  = rf_we_q;
  assign memRead        = mem_read_q;
  assign memWrite       = mem_write_q;
  assign aluSrc         = alu_src_q;
  assign bitXtend       = bit_xtend_q;
  assign aluFunc        = alu_func_q;
  assign invOpcode      = inv_q;
  assign memErr         = err_q;
  assign state          = state_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: scoreboarded random instruction stream on a default
// instance, plus directed timeout/halt/reset cases and a narrow-counter, no-immediate instance.
module tb_multicycle_control_unit;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3;
  localparam logic [3:0] S_MEMWR = 4'd5, S_WB = 4'd6, S_HALT = 4'd9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic        rst_n, mem_ready, auto_mem, auto_ready, man_ready;
  logic [5:0]  opc, func, auto_opc, auto_func, man_opc, man_func;
  logic        ir_write, pc_write, iord, is_jmp, is_beq, is_bne, rf_waddr_sel, rf_we;
  logic        mem_read, mem_write, alu_src, bit_xtend, inv_opcode, mem_err;
  logic [1:0]  rf_wdata_sel;
  logic [2:0]  alu_func;
  logic [3:0]  state;
  logic [31:0] retired;
  logic [16:0] ctrl_a;

  assign mem_ready = auto_mem ? auto_ready : man_ready;
  assign opc       = auto_mem ? auto_opc : man_opc;
  assign func      = auto_mem ? auto_func : man_func;
  assign ctrl_a = {ir_write, pc_write, iord, is_jmp, is_beq, is_bne, rf_wdata_sel, rf_waddr_sel,
                   rf_we, mem_read, mem_write, alu_src, bit_xtend, alu_func};

  multicycle_control_unit dut_a (
    .clk(clk), .rst_n(rst_n), .opc(opc), .func(func), .memReady(mem_ready),
    .irWrite(ir_write), .pcWrite(pc_write), .iorD(iord), .isJmp(is_jmp), .isBeq(is_beq),
    .isBne(is_bne), .rfWriteDataSel(rf_wdata_sel), .rfWriteAddrSel(rf_waddr_sel),
    .rfWriteEnable(rf_we), .memRead(mem_read), .memWrite(mem_write), .aluSrc(alu_src),
    .bitXtend(bit_xtend), .aluFunc(alu_func), .invOpcode(inv_opcode), .memErr(mem_err),
    .state(state), .retired(retired)
  );

  // Instance B: 4-bit counter, immediates disabled.
  logic        rst_nb, ready_b;
  logic [5:0]  opc_b, func_b;
  logic        ir_write_b, pc_write_b, iord_b, is_jmp_b, is_beq_b, is_bne_b, rf_waddr_sel_b;
  logic        rf_we_b, mem_read_b, mem_write_b, alu_src_b, bit_xtend_b, inv_opcode_b, mem_err_b;
  logic [1:0]  rf_wdata_sel_b;
  logic [2:0]  alu_func_b;
  logic [3:0]  state_b, retired_b;
  logic [16:0] ctrl_b;

  assign ctrl_b = {ir_write_b, pc_write_b, iord_b, is_jmp_b, is_beq_b, is_bne_b, rf_wdata_sel_b,
                   rf_waddr_sel_b, rf_we_b, mem_read_b, mem_write_b, alu_src_b, bit_xtend_b,
                   alu_func_b};

  multicycle_control_unit #(.MEM_TIMEOUT(15), .CNT_WIDTH(4), .ENABLE_IMM(0)) dut_b (
    .clk(clk), .rst_n(rst_nb), .opc(opc_b), .func(func_b), .memReady(ready_b),
    .irWrite(ir_write_b), .pcWrite(pc_write_b), .iorD(iord_b), .isJmp(is_jmp_b),
    .isBeq(is_beq_b), .isBne(is_bne_b), .rfWriteDataSel(rf_wdata_sel_b),
    .rfWriteAddrSel(rf_waddr_sel_b), .rfWriteEnable(rf_we_b), .memRead(mem_read_b),
    .memWrite(mem_write_b), .aluSrc(alu_src_b), .bitXtend(bit_xtend_b), .aluFunc(alu_func_b),
    .invOpcode(inv_opcode_b), .memErr(mem_err_b), .state(state_b), .retired(retired_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  func;
    int unsigned fw;
    int unsigned mw;
  } instr_t;

  typedef struct {
    logic [4:0]  strobes;  // {rfWriteEnable, isBeq, isBne, isJmp, store handshake}
    logic        has_exec;
    logic [2:0]  exec_alu;
    logic        exec_src;
    logic        exec_zext;
    logic        waddr;
    logic [1:0]  wdata;
    logic [2:0]  ret_alu;
    int unsigned cycles;
    logic [31:0] ret;
  } exp_t;

  function automatic instr_t pick(int unsigned k);
    instr_t r;
    r.fw   = $urandom_range(3);
    r.mw   = $urandom_range(3);
    r.func = 6'($urandom);
    case (k)
      0:  begin r.opc = 6'h00; r.func = 6'h20; end
      1:  begin r.opc = 6'h00; r.func = 6'h22; end
      2:  begin r.opc = 6'h00; r.func = 6'h24; end
      3:  begin r.opc = 6'h00; r.func = 6'h25; end
      4:  begin r.opc = 6'h00; r.func = 6'h2A; end
      5:  r.opc = 6'h08;
      6:  r.opc = 6'h0A;
      7:  r.opc = 6'h0C;
      8:  r.opc = 6'h0D;
      9:  r.opc = 6'h23;
      10: r.opc = 6'h2B;
      11: r.opc = 6'h04;
      12: r.opc = 6'h05;
      default: r.opc = 6'h02;
    endcase
    return r;
  endfunction

  // Reference model: what one instruction should look like from the outside.
  function automatic exp_t model(instr_t i, logic [31:0] ret);
    exp_t e;
    e.strobes = 5'b0; e.has_exec = 1'b0; e.exec_alu = 3'b0; e.exec_src = 1'b0;
    e.exec_zext = 1'b0; e.waddr = 1'b0; e.wdata = 2'b00; e.ret_alu = 3'b0; e.ret = ret;
    e.cycles = 0;
    case (i.opc)
      6'h00: begin
        e.strobes = 5'b10000; e.has_exec = 1'b1; e.waddr = 1'b1; e.cycles = 4 + i.fw;
        case (i.func)
          6'h20:   e.exec_alu = ALU_ADD;
          6'h22:   e.exec_alu = ALU_SUB;
          6'h24:   e.exec_alu = ALU_AND;
          6'h25:   e.exec_alu = ALU_OR;
          default: e.exec_alu = ALU_SLT;
        endcase
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        e.strobes = 5'b10000; e.has_exec = 1'b1; e.exec_src = 1'b1; e.cycles = 4 + i.fw;
        e.exec_zext = (i.opc == 6'h0C) || (i.opc == 6'h0D);
        case (i.opc)
          6'h08:   e.exec_alu = ALU_ADD;
          6'h0A:   e.exec_alu = ALU_SLT;
          6'h0C:   e.exec_alu = ALU_AND;
          default: e.exec_alu = ALU_OR;
        endcase
      end
      6'h23: begin
        e.strobes = 5'b10000; e.has_exec = 1'b1; e.exec_src = 1'b1; e.exec_alu = ALU_ADD;
        e.wdata = 2'b01; e.cycles = 5 + i.fw + i.mw;
      end
      6'h2B: begin
        e.strobes = 5'b00001; e.has_exec = 1'b1; e.exec_src = 1'b1; e.exec_alu = ALU_ADD;
        e.cycles = 4 + i.fw + i.mw;
      end
      6'h04: begin e.strobes = 5'b01000; e.ret_alu = ALU_SUB; e.cycles = 3 + i.fw; end
      6'h05: begin e.strobes = 5'b00100; e.ret_alu = ALU_SUB; e.cycles = 3 + i.fw; end
      default: begin e.strobes = 5'b00010; e.cycles = 3 + i.fw; end
    endcase
    return e;
  endfunction

  instr_t      iq[$];
  exp_t        eq[$];
  instr_t      cur;
  exp_t        mon_e;
  bit          busy, ret_pend, exec_seen;
  int unsigned left, cyc;
  logic [31:0] ret_exp;
  logic [2:0]  exec_alu_s;
  logic        exec_src_s, exec_zext_s;
  logic [4:0]  strobes;

  // Memory responder, then monitor/scoreboard, both at the negedge.
  always @(negedge clk) begin
    if (!auto_mem) begin
      busy = 0; ret_pend = 0; exec_seen = 0; cyc = 0; auto_ready = 1'b0;
    end else begin
      if ((mem_read || mem_write) && !busy) begin
        if (!iord) begin
          if (iq.size() > 0) begin cur = iq.pop_front(); busy = 1; left = cur.fw; end
        end else begin
          busy = 1; left = cur.mw;
        end
      end
      if (busy && left == 0) begin
        auto_ready = 1'b1;
        busy = 0;
        if (!iord) begin auto_opc = cur.opc; auto_func = cur.func; end
      end else begin
        auto_ready = 1'b0;
        if (busy) left--;
      end

      if (ret_pend) begin check("retired_count", retired, ret_exp); ret_pend = 0; end
      if (state != S_IDLE && state != S_HALT) cyc++;
      if (state == S_EXEC) begin
        exec_seen = 1; exec_alu_s = alu_func; exec_src_s = alu_src; exec_zext_s = bit_xtend;
      end
      strobes = {rf_we, is_beq, is_bne, is_jmp, mem_write && auto_ready};
      if (strobes != 5'b0) begin
        if (eq.size() == 0) begin
          check("unexpected_retire", 32'(strobes), 32'd0);
        end else begin
          mon_e = eq.pop_front();
          check("retire_strobes", 32'(strobes), 32'(mon_e.strobes));
          check("instr_cycles", cyc, mon_e.cycles);
          check("retire_alu", 32'(alu_func), 32'(mon_e.ret_alu));
          check("wb_sel", {rf_waddr_sel, rf_wdata_sel}, {mon_e.waddr, mon_e.wdata});
          check("exec_seen", 32'(exec_seen), 32'(mon_e.has_exec));
          if (mon_e.has_exec)
            check("exec_ctrl", {exec_alu_s, exec_src_s, exec_zext_s},
                  {mon_e.exec_alu, mon_e.exec_src, mon_e.exec_zext});
          ret_exp  = mon_e.ret;
          ret_pend = 1;
        end
        cyc = 0;
        exec_seen = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic reset_a();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  add_seq [5];
    logic [31:0] model_ret;
    int          bad;
    instr_t      ins;

    add_seq = '{S_FETCH, S_DECODE, S_EXEC, S_WB, S_FETCH};
    rst_n = 1'b0; rst_nb = 1'b0; auto_mem = 1'b0; man_ready = 1'b0;
    man_opc = 6'h00; man_func = 6'h00; auto_opc = 6'h00; auto_func = 6'h00; auto_ready = 1'b0;
    opc_b = 6'h00; func_b = 6'h20; ready_b = 1'b0;
    #12;
    check("reset_state", state, S_IDLE);
    check("reset_retired", retired, 32'd0);
    check("reset_ctrl", ctrl_a, 17'd0);
    check("reset_flags", {inv_opcode, mem_err}, 2'b00);

    // Random stream: one of each type first, then random picks.
    model_ret = 0;
    for (int n = 0; n < 40; n++) begin
      ins = pick((n < 14) ? n : $urandom_range(13));
      model_ret++;
      iq.push_back(ins);
      eq.push_back(model(ins, model_ret));
    end
    auto_mem = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000 && eq.size() != 0; c++) @(negedge clk);
    check("scoreboard_drain", eq.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    auto_mem = 1'b0;
    rst_n = 1'b0;

    // add trace with memReady always high.
    man_opc = 6'h00; man_func = 6'h20; man_ready = 1'b1;
    reset_a();
    check("add_idle", state, S_IDLE);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("add_state", state, add_seq[k]);
      if (k == 0) check("fetch_strobes", {ir_write, pc_write}, 2'b11);
      if (k == 2) check("add_exec", {alu_func, alu_src}, {ALU_ADD, 1'b0});
      if (k == 3) check("add_wb", {rf_we, rf_waddr_sel, rf_wdata_sel}, 4'b1100);
      if (k == 4) check("add_retired", retired, 32'd1);
    end

    // Fetch timeout after 15 waiting cycles.
    man_ready = 1'b0;
    reset_a();
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (state != S_FETCH || !mem_read) bad++;
    end
    check("timeout_fetch_wait", bad, 0);
    @(negedge clk);
    check("timeout_state", state, S_HALT);
    check("timeout_flags", {mem_err, inv_opcode}, 2'b10);
    man_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state != S_HALT || ctrl_a != 17'd0 || !mem_err) bad++;
    end
    check("timeout_halt_quiet", bad, 0);

    // memReady on the limit cycle beats the timeout.
    man_ready = 1'b0;
    reset_a();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 15) man_ready = 1'b1;
    end
    @(negedge clk);
    check("limit_ready_state", state, S_DECODE);
    check("limit_ready_err", mem_err, 1'b0);

    // Invalid opcode.
    man_opc = 6'h3F; man_ready = 1'b1;
    reset_a();
    repeat (3) @(negedge clk);
    check("inv_state", state, S_HALT);
    check("inv_flags", {inv_opcode, mem_err}, 2'b10);
    check("inv_retired", retired, 32'd0);

    // Reset asserted while a store waits in MEM_WR.
    man_opc = 6'h2B; man_ready = 1'b1;
    reset_a();
    @(negedge clk);
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sw_memwr", {state, mem_write, iord}, {S_MEMWR, 2'b11});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_immediate", {state, mem_write, iord}, {S_IDLE, 2'b00});
    @(negedge clk);
    @(negedge clk);
    check("abort_held", {state, mem_write}, {S_IDLE, 1'b0});

    // Instance B: counter wrap, then ori rejected.
    ready_b = 1'b1;
    @(negedge clk);
    rst_nb = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 61) check("wrap_pre", 32'(retired_b), 32'd15);
      if (k == 65) begin
        check("wrap_zero", 32'(retired_b), 32'd0);
        check("wrap_state", state_b, S_FETCH);
        opc_b = 6'h0D;
      end
    end
    @(negedge clk);
    @(negedge clk);
    check("ori_disabled_state", state_b, S_HALT);
    check("ori_disabled_flags", {inv_opcode_b, mem_err_b}, 2'b10);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (state_b != S_HALT || ctrl_b != 17'd0 || retired_b != 4'd0 || !inv_opcode_b) bad++;
    end
    check("ori_halt_quiet", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
